axi_fifo_o_wr_sched: RTL and testbench

- Round-robin write scheduler sitting on the read side of N_CH prefetch output FIFOs (valid/enable read interface, first-word-fall-through data).
- Grants one channel at a time and issues one fixed-length AXI4 write burst per grant: AW, then BURST_LEN W beats popped from that channel's FIFO, then B.
- Keeps a per-channel frame offset that advances BURST_LEN beats per completed burst and wraps at the frame size.
- Runs entirely in the rd_clk domain.

---
 rtl/axi_fifo_o_wr_sched_if.sv | 27 ++
 rtl/axi_fifo_o_wr_sched.sv | 116 +++++++++++
 tb/tb_axi_fifo_o_wr_sched.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_fifo_o_wr_sched_if.sv
// axi_fifo_o_wr_sched_if: AXI4 write-channel bundle (AW, W, B) between scheduler and memory.
interface axi_fifo_o_wr_sched_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wlast;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;

    modport master (
        output awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  awaddr, awlen, awvalid, wdata, wvalid, wlast, bready,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_fifo_o_wr_sched.sv
// axi_fifo_o_wr_sched: round-robin scheduler draining N_CH FWFT FIFOs as fixed-length AXI4 write bursts.
module axi_fifo_o_wr_sched #(
    parameter int N_CH      = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 16,
    parameter int FRM_W     = 20
) (
    input  logic                     rd_clk,
    input  logic                     rd_rst,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_frm_rst,
    input  logic [N_CH*ADDR_W-1:0]   ch_base,
    input  logic [FRM_W-1:0]         frame_beats,
    input  logic [N_CH*DATA_W-1:0]   fifo_rd_data,
    input  logic [N_CH-1:0]          fifo_rd_vld,
    output logic [N_CH-1:0]          fifo_rd_en,
    axi_fifo_o_wr_sched_if.master    m,
    output logic                     busy,
    output logic [N_CH-1:0]          grant,
    output logic                     err
);
    localparam int CW = $clog2(N_CH);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     ptr, gi, sel, j;
    logic              found;
    logic [BW-1:0]     beat_cnt;
    logic [FRM_W-1:0]  offset [N_CH];
    logic [N_CH-1:0]   pend;
    logic [FRM_W:0]    off_sum;
    logic              off_wrap;
    logic [FRM_W-1:0]  off_sel;
    logic              w_xfer;
    logic              last;

    // Walk downwards so the requester closest to ptr (cyclically) wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        j     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            j = CW'((int'(ptr) + k) % N_CH);
            if (ch_req[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
    end

    // A restart arriving on the grant cycle must already apply to this burst's address.
    assign off_sel  = ch_frm_rst[sel] ? '0 : offset[sel];
    assign off_sum  = {1'b0, offset[gi]} + (FRM_W + 1)'(BURST_LEN);
    assign off_wrap = (frame_beats == '0) ? off_sum[FRM_W] : (off_sum >= {1'b0, frame_beats});
    assign w_xfer   = (state == W) && fifo_rd_vld[gi] && m.wready;
    assign last     = beat_cnt == BW'(BURST_LEN - 1);

    assign m.awvalid  = state == AW;
    assign m.awlen    = 8'(BURST_LEN - 1);
    assign m.wvalid   = (state == W) && fifo_rd_vld[gi];
    assign m.wdata    = (state == W) ? fifo_rd_data[gi*DATA_W +: DATA_W] : '0;
    assign m.wlast    = (state == W) && last;
    assign m.bready   = state == B;
    assign fifo_rd_en = ((state == W) && m.wready) ? grant : '0;
    assign busy       = state != IDLE;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = found ? AW : IDLE;
            AW:   state_nx = m.awready ? W : AW;
            W:    state_nx = (w_xfer && last) ? B : W;
            B:    state_nx = m.bvalid ? IDLE : B;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            ptr      <= '0;
            gi       <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            m.awaddr <= '0;
            err      <= 1'b0;
            pend     <= '0;
            for (int i = 0; i < N_CH; i++) offset[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_frm_rst[i] && grant[i]) pend[i] <= 1'b1;
                if (ch_frm_rst[i] && !grant[i]) offset[i] <= '0;
            end
            if (state == IDLE && found) begin
                gi       <= sel;
                grant    <= N_CH'(1) << sel;
                m.awaddr <= ch_base[sel*ADDR_W +: ADDR_W] + ADDR_W'(off_sel) * ADDR_W'(DATA_W / 8);
            end
            if (state == AW) beat_cnt <= '0;
            if (w_xfer) beat_cnt <= beat_cnt + BW'(1);
            if (state == B && m.bvalid) begin
                err        <= err | (m.bresp != 2'b00);
                offset[gi] <= (pend[gi] || ch_frm_rst[gi] || off_wrap) ? '0 : off_sum[FRM_W-1:0];
                pend[gi]   <= 1'b0;
                ptr        <= (gi == CW'(N_CH - 1)) ? '0 : gi + CW'(1);
                grant      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_axi_fifo_o_wr_sched.sv
// tb_axi_fifo_o_wr_sched: directed bursts with AXI slave/FIFO models and a queue-based scoreboard.
module tb_axi_fifo_o_wr_sched;
    localparam int AW_W = 32;
    localparam int DW   = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  gnt;
    } aw_t;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic [1:0]  ch_req = '0;
    logic [1:0]  ch_frm_rst = '0;
    logic [63:0] ch_base = {32'h2000_0000, 32'h1000_0000};
    logic [19:0] frame_beats = 20'd64;
    logic [63:0] fifo_rd_data;
    logic [1:0]  fifo_rd_vld = 2'b11;
    logic [1:0]  fifo_rd_en;
    logic [1:0]  grant;
    logic        busy;
    logic        err;

    axi_fifo_o_wr_sched_if #(.ADDR_W(AW_W), .DATA_W(DW)) m ();

    axi_fifo_o_wr_sched dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .ch_req       (ch_req),
        .ch_frm_rst   (ch_frm_rst),
        .ch_base      (ch_base),
        .frame_beats  (frame_beats),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .m            (m),
        .busy         (busy),
        .grant        (grant),
        .err          (err)
    );

    always #5 rd_clk = ~rd_clk;

    int         cnt [2] = '{0, 0};
    int         ew [2] = '{0, 0};
    aw_t        aw_q [$];
    logic [32:0] w_q [$];
    int         checks = 0;
    int         fails = 0;
    int         bcount = 0;
    int         wbeats = 0;
    int         holes = 0;
    logic [1:0] pop_pend = '0;
    int         aw_delay = 0;
    int         aw_wait = 0;
    int         hole = 0;
    bit         wtog = 1'b0;
    bit         bad = 1'b0;

    // FIFO words carry channel+1 in the top byte and a running index below.
    assign fifo_rd_data = {8'd2, cnt[1][23:0], 8'd1, cnt[0][23:0]};

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outs(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_awvalid"}, m.awvalid, 0);
        chk({tag, "_wvalid"}, m.wvalid, 0);
        chk({tag, "_wlast"}, m.wlast, 0);
        chk({tag, "_bready"}, m.bready, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
    endtask

    task automatic push_burst(int c, logic [31:0] a);
        aw_t x;
        x.addr = a;
        x.gnt  = 2'(1 << c);
        aw_q.push_back(x);
        for (int i = 0; i < 16; i++) w_q.push_back({i == 15, 8'(c + 1), 24'(ew[c] + i)});
        ew[c] += 16;
    endtask

    task automatic wait_b(int target);
        for (int t = 0; t < 3000 && bcount < target; t++) begin
            @(negedge rd_clk);
            #1;
        end
        if (bcount < target) begin
            checks++;
            fails++;
            $display("FAIL b_timeout: got %0d responses expected %0d", bcount, target);
        end
    endtask

    task automatic wait_w(int target);
        for (int t = 0; t < 3000 && wbeats < target; t++) begin
            @(negedge rd_clk);
            #1;
        end
        if (wbeats < target) begin
            checks++;
            fails++;
            $display("FAIL w_timeout: got %0d beats expected %0d", wbeats, target);
        end
    endtask

    // AXI slave and FIFO model: inputs change only just after the active edge.
    initial begin
        m.awready = 1'b0;
        m.wready  = 1'b1;
        m.bvalid  = 1'b0;
        m.bresp   = 2'b00;
        forever begin
            @(posedge rd_clk);
            #1;
            if (!rd_rst) for (int i = 0; i < 2; i++) if (pop_pend[i]) cnt[i]++;
            if (m.awvalid) begin
                if (aw_wait == aw_delay) m.awready = 1'b1;
                else begin
                    m.awready = 1'b0;
                    aw_wait++;
                end
            end else begin
                m.awready = 1'b0;
                aw_wait = 0;
            end
            m.wready = wtog ? ~m.wready : 1'b1;
            m.bvalid = m.bready;
            m.bresp  = (m.bready && bad) ? 2'b10 : 2'b00;
            if (hole > 0) begin
                fifo_rd_vld[0] = 1'b0;
                hole--;
            end else fifo_rd_vld[0] = 1'b1;
        end
    end

    // Monitor: the handshakes seen here complete on the following rising edge.
    initial forever begin
        @(negedge rd_clk);
        if (rd_rst) pop_pend = '0;
        else begin
            pop_pend = fifo_rd_en & fifo_rd_vld;
            chk("rd_en_leak", fifo_rd_en & ~grant, 0);
            if (m.awvalid) begin
                if (aw_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL aw_unexpected: got addr %h expected none", m.awaddr);
                end else begin
                    chk("awaddr", m.awaddr, aw_q[0].addr);
                    chk("aw_grant", grant, aw_q[0].gnt);
                    if (m.awready) void'(aw_q.pop_front());
                end
            end
            if (busy && (grant & fifo_rd_vld) == 0) begin
                holes++;
                chk("wvalid_hole", m.wvalid, 0);
            end
            if (m.wvalid && m.wready) begin
                wbeats++;
                if (w_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL w_unexpected: got data %h expected none", m.wdata);
                end else begin
                    logic [32:0] e;
                    e = w_q.pop_front();
                    chk("wdata", m.wdata, e[31:0]);
                    chk("wlast", m.wlast, e[32]);
                end
            end
            if (m.bvalid && m.bready) bcount++;
        end
    end

    initial begin
        int start, h0;
        repeat (3) @(negedge rd_clk);
        #1;
        chk_reset_outs("reset");
        chk("awlen", m.awlen, 8'd15);
        rd_rst = 1'b0;

        // Single channel, offset wraps after four bursts of a 64-beat frame.
        ch_req = 2'b01;
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0040);
        push_burst(0, 32'h1000_0080);
        push_burst(0, 32'h1000_00C0);
        push_burst(0, 32'h1000_0000);
        wait_b(5);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;

        rd_rst = 1'b1;
        @(negedge rd_clk);
        #1;
        chk_reset_outs("reset2");
        rd_rst = 1'b0;

        // Both channels requesting: strict alternation.
        ch_req = 2'b11;
        push_burst(0, 32'h1000_0000);
        push_burst(1, 32'h2000_0000);
        push_burst(0, 32'h1000_0040);
        push_burst(1, 32'h2000_0040);
        wait_b(9);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;

        // Backpressure on AW and W.
        aw_delay = 5;
        wtog = 1'b1;
        start = cnt[1];
        ch_req = 2'b10;
        push_burst(1, 32'h2000_0080);
        wait_b(10);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;
        chk("pops_ch1", cnt[1] - start, 16);
        aw_delay = 0;
        wtog = 1'b0;
        repeat (2) @(negedge rd_clk);
        #1;

        // FIFO underflow for four cycles mid-burst.
        h0 = holes;
        ch_req = 2'b01;
        push_burst(0, 32'h1000_0080);
        wait_w(wbeats + 7);
        hole = 4;
        wait_b(11);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;
        chk("hole_cycles", holes - h0, 4);

        // Error response sets sticky err; following burst still runs.
        chk("err_before", err, 0);
        bad = 1'b1;
        ch_req = 2'b01;
        push_burst(0, 32'h1000_00C0);
        push_burst(0, 32'h1000_0000);
        wait_b(12);
        bad = 1'b0;
        @(negedge rd_clk);
        #1;
        chk("err_set", err, 1);
        wait_b(13);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;
        chk("err_sticky", err, 1);
        rd_rst = 1'b1;
        #1;
        chk("err_cleared", err, 0);
        @(negedge rd_clk);
        #1;
        rd_rst = 1'b0;

        // Frame restart during channel 0's burst at offset 32.
        ch_req = 2'b01;
        push_burst(0, 32'h1000_0000);
        push_burst(0, 32'h1000_0040);
        push_burst(0, 32'h1000_0080);
        push_burst(0, 32'h1000_0000);
        wait_b(15);
        wait_w(wbeats + 3);
        chk("frm_rst_in_w", grant, 2'b01);
        ch_frm_rst = 2'b01;
        @(negedge rd_clk);
        #1;
        ch_frm_rst = 2'b00;
        wait_b(17);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;

        // Reset in the middle of a W phase.
        ch_req = 2'b01;
        push_burst(0, 32'h1000_0040);
        wait_w(wbeats + 5);
        rd_rst = 1'b1;
        #1;
        chk_reset_outs("mid_w_reset");
        ch_req = 2'b00;
        repeat (2) @(negedge rd_clk);
        #1;
        aw_q.delete();
        w_q.delete();
        ew[0] = cnt[0];
        rd_rst = 1'b0;
        ch_req = 2'b01;
        push_burst(0, 32'h1000_0000);
        wait_b(bcount + 1);
        ch_req = 2'b00;
        repeat (3) @(negedge rd_clk);
        #1;

        chk("aw_q_empty", aw_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
